l2_host_rsp_ctrl: RTL

//  Host-side responder for an L2 stream: accepts cache-line read requests (EA) from a stream pointer,

---
 rtl/l2_host_rsp_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/l2_host_rsp_ctrl.sv
// Purpose: tags stream read requests, issues them to the host, steers tagged host responses to URAM slots, retires in order.
// Latency: request -> host request 1 cycle; host response -> URAM write same cycle; host response -> completion >= 1 cycle.
// Backpressure: i_req_r drops when all tags are allocated or a pending host request is stalled; host responses are always accepted.
module l2_host_rsp_ctrl #(
    parameter int addr_width       = 64,
    parameter int cache_line       = 128,
    parameter int cache_line_width = $clog2(cache_line),
    parameter int l2_ncl           = 256,
    parameter int l2_ncl_width     = $clog2(l2_ncl),
    parameter int ntag             = 32,
    parameter int tag_width        = $clog2(ntag),
    parameter int cnt_width        = $clog2(ntag + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req_v,
    output logic                    i_req_r,
    input  logic [addr_width-1:0]   i_req_ea,
    output logic                    o_hreq_v,
    input  logic                    o_hreq_r,
    output logic [addr_width-1:0]   o_hreq_ea,
    output logic [tag_width-1:0]    o_hreq_tag,
    input  logic                    i_hrsp_v,
    output logic                    i_hrsp_r,
    input  logic [tag_width-1:0]    i_hrsp_tag,
    output logic                    o_wr_v,
    output logic [l2_ncl_width-1:0] o_wr_ptr,
    output logic                    o_rsp_v,
    input  logic                    o_rsp_r,
    output logic [cnt_width-1:0]    o_cnt,
    output logic                    o_idle,
    output logic                    o_err
);

    localparam logic [cnt_width-1:0] full_cnt = cnt_width'(ntag);

    logic [tag_width-1:0]    head;
    logic [tag_width-1:0]    tail;
    logic [cnt_width-1:0]    cnt;
    logic [ntag-1:0]         inflight;
    logic [ntag-1:0]         done;
    logic [l2_ncl_width-1:0] slot [ntag];
    logic                    hreq_v;
    logic [addr_width-1:0]   hreq_ea;
    logic [tag_width-1:0]    hreq_tag;
    logic                    err;

    logic alloc;
    logic wr;
    logic retire;

    // Handshake decodes; fullness comes from the registered count so a same-cycle retire cannot reopen the input.
    always_comb begin
        i_req_r = (cnt != full_cnt) & (~hreq_v | o_hreq_r);
        alloc   = i_req_v & i_req_r;
        wr      = i_hrsp_v & inflight[i_hrsp_tag] & ~done[i_hrsp_tag];
        o_rsp_v = done[head] & inflight[head];
        retire  = o_rsp_v & o_rsp_r;
    end

    assign i_hrsp_r   = 1'b1;
    assign o_wr_v     = wr;
    assign o_wr_ptr   = slot[i_hrsp_tag];
    assign o_hreq_v   = hreq_v;
    assign o_hreq_ea  = hreq_ea;
    assign o_hreq_tag = hreq_tag;
    assign o_cnt      = cnt;
    assign o_idle     = (cnt == '0) & ~hreq_v;
    assign o_err      = err;

    // Host request register: load on allocate, hold while stalled, drop after handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hreq_v   <= 1'b0;
            hreq_ea  <= '0;
            hreq_tag <= '0;
        end else if (alloc) begin
            hreq_v   <= 1'b1;
            hreq_ea  <= i_req_ea;
            hreq_tag <= tail;
        end else if (o_hreq_r) begin
            hreq_v   <= 1'b0;
        end
    end

    // Ring pointers and outstanding count; allocate and retire together leave the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (alloc)  tail <= tail + 1'b1;
            if (retire) head <= head + 1'b1;
            case ({alloc, retire})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Per-tag status; retire, response and allocate always touch distinct tags in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= '0;
            done     <= '0;
        end else begin
            if (retire) begin
                inflight[head] <= 1'b0;
                done[head]     <= 1'b0;
            end
            if (wr) done[i_hrsp_tag] <= 1'b1;
            if (alloc) begin
                inflight[tail] <= 1'b1;
                done[tail]     <= 1'b0;
            end
        end
    end

    // URAM line slot captured from the request EA at allocation time.
    always_ff @(posedge clk) begin
        if (alloc) slot[tail] <= i_req_ea[l2_ncl_width+cache_line_width-1:cache_line_width];
    end

    // Sticky error for responses whose tag is not in flight or already answered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                err <= 1'b0;
        else if (i_hrsp_v & ~wr)  err <= 1'b1;
    end

endmodule
